// File: rtl/sram_pkg.sv
// Shared widths and types for the SRAM arbiter slice.
// Pipeline entries carry a valid bit plus the requester's opaque read tag.
package sram_pkg;

   localparam int unsigned SRAM_ADDR_W        = 20;
   localparam int unsigned SRAM_DATA_W        = 17;
   localparam int unsigned SRAM_TAG_W         = 4;
   localparam int unsigned SRAM_READ_LATENCY  = 4;
   localparam int unsigned SRAM_WR_STARVE_MAX = 8;

   typedef struct packed {
      logic                  valid;
      logic [SRAM_TAG_W-1:0] tag;
   } rd_entry_t;

   typedef enum logic [1:0] {
      GntIdle,
      GntRead,
      GntWrite
   } gnt_e;

endpackage

// File: rtl/sram_read_tracker.sv
// Delay line of {valid, tag} matching the SRAM read latency, plus return registers
// and a count of reads still in flight.
module sram_read_tracker
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W       = SRAM_DATA_W,
   parameter int unsigned READ_LATENCY = SRAM_READ_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [SRAM_TAG_W-1:0] push_tag,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic [SRAM_TAG_W-1:0] rd_tag_out,
   output logic [2:0]            outstanding
);

   // One extra stage covers the issue register sitting in front of the interface.
   localparam int unsigned Depth = READ_LATENCY + 1;

   rd_entry_t [Depth-1:0] pipe_q, pipe_d;
   rd_entry_t             head;
   logic                  rd_valid_q;
   logic [DATA_W-1:0]     rd_data_q;
   logic [SRAM_TAG_W-1:0] rd_tag_q;

   always_comb begin
      head       = '0;
      head.valid = push;
      head.tag   = push_tag;
      pipe_d     = {pipe_q[Depth-2:0], head};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_tag_q   <= '0;
      end else begin
         pipe_q     <= pipe_d;
         rd_valid_q <= pipe_q[Depth-1].valid;
         if (pipe_q[Depth-1].valid) begin
            rd_data_q <= mem_rdata;
            rd_tag_q  <= pipe_q[Depth-1].tag;
         end
      end
   end

   always_comb begin
      outstanding = '0;
      for (int unsigned i = 0; i < Depth; i++) begin
         outstanding = outstanding + 3'(pipe_q[i].valid);
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign rd_tag_out = rd_tag_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter onto the pipelined SRAM interface: read priority, with a
// starvation counter that forces a waiting write through after WR_STARVE_MAX refusals.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned ADDR_W        = SRAM_ADDR_W,
   parameter int unsigned DATA_W        = SRAM_DATA_W,
   parameter int unsigned TAG_W         = SRAM_TAG_W,
   parameter int unsigned READ_LATENCY  = SRAM_READ_LATENCY,
   parameter int unsigned WR_STARVE_MAX = SRAM_WR_STARVE_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic              rd_gnt,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [TAG_W-1:0]  rd_tag_out,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [2:0]        rd_outstanding
);

   localparam int unsigned StarveW = $clog2(WR_STARVE_MAX + 1);
   localparam logic [StarveW-1:0] StarveMax = StarveW'(WR_STARVE_MAX);

   gnt_e              gnt;
   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   // Grants are masked during reset so nothing is accepted while rst is high.
   always_comb begin
      gnt = GntIdle;
      if (!rst) begin
         if (rd_req && (!wr_req || (starve_cnt_q != StarveMax))) begin
            gnt = GntRead;
         end else if (wr_req) begin
            gnt = GntWrite;
         end
      end
   end

   assign rd_gnt = (gnt == GntRead);
   assign wr_gnt = (gnt == GntWrite);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!wr_req || wr_gnt) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != StarveMax) begin
         starve_cnt_d = starve_cnt_q + 1'b1;
      end
   end

   // Idle cycles leave address/data alone; the interface sees an untracked dummy read.
   always_comb begin
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      unique case (gnt)
         GntWrite: begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
         end
         GntRead: begin
            mem_addr_d = rd_addr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

   sram_read_tracker #(
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY)
   ) u_read_tracker (
      .clk         (clk),
      .rst         (rst),
      .push        (rd_gnt),
      .push_tag    (rd_tag),
      .mem_rdata   (mem_rdata),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_tag_out  (rd_tag_out),
      .outstanding (rd_outstanding)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: an SRAM model on the mem_* port and a
// scoreboard of expected read returns checked with immediate assertions.
module tb_sram_arbiter;

   logic        clk;
   logic        rst;
   logic        rd_req;
   logic [19:0] rd_addr;
   logic [3:0]  rd_tag;
   logic        rd_gnt;
   logic        rd_valid;
   logic [16:0] rd_data;
   logic [3:0]  rd_tag_out;
   logic        wr_req;
   logic [19:0] wr_addr;
   logic [16:0] wr_data;
   logic        wr_gnt;
   logic        mem_we;
   logic [19:0] mem_addr;
   logic [16:0] mem_wdata;
   logic [16:0] mem_rdata;
   logic [2:0]  rd_outstanding;

   sram_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_tag         (rd_tag),
      .rd_gnt         (rd_gnt),
      .rd_valid       (rd_valid),
      .rd_data        (rd_data),
      .rd_tag_out     (rd_tag_out),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .wr_gnt         (wr_gnt),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .rd_outstanding (rd_outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [16:0] pattern(input logic [9:0] a);
      if (a == 10'h010) return 17'h1ABCD;
      return 17'(a) * 17'd37 + 17'd5;
   endfunction

   // SRAM model: latches mem_* one edge after issue, data_out valid 4 edges later.
   logic [16:0] mem     [1024];
   logic        mem_wr  [1024];
   logic [16:0] rpipe   [4];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[9:0]]    <= mem_wdata;
         mem_wr[mem_addr[9:0]] <= 1'b1;
      end
      rpipe[0] <= (mem_wr[mem_addr[9:0]] === 1'b1) ? mem[mem_addr[9:0]] : pattern(mem_addr[9:0]);
      for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
   end

   assign mem_rdata = rpipe[3];

   // Reference view of memory contents, updated from accepted writes in order.
   logic [16:0] shadow    [1024];
   logic        shadow_wr [1024];
   logic [16:0] exp_wdata;

   function automatic logic [16:0] shadow_val(input logic [9:0] a);
      return (shadow_wr[a] === 1'b1) ? shadow[a] : pattern(a);
   endfunction

   typedef struct {
      logic [3:0]  tag;
      logic [16:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t pop_e;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         exp_wdata = '0;
      end else begin
         if (rd_req && rd_gnt) sb.push_back('{rd_tag, shadow_val(rd_addr[9:0]), cyc});
         if (wr_req && wr_gnt) begin
            shadow[wr_addr[9:0]]    = wr_data;
            shadow_wr[wr_addr[9:0]] = 1'b1;
            exp_wdata               = wr_data;
         end
         if (rd_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_rd_valid", 32'(rd_valid), 32'(0));
            end else begin
               pop_e = sb.pop_front();
               chk("rd_data", 32'(rd_data), 32'(pop_e.data));
               chk("rd_tag_out", 32'(rd_tag_out), 32'(pop_e.tag));
               chk("rd_latency", 32'(cyc - pop_e.cyc), 32'(6));
            end
         end
      end
   end

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0) break;
      end
      chk("drain_scoreboard_empty", 32'(sb.size()), 32'(0));
   endtask

   // Both ports request every cycle; a write must win once the counter reaches 8.
   task automatic run_contention(input int cycles);
      int  mcnt;
      bit  exp_w;
      mcnt = 0;
      @(posedge clk);
      #1;
      rd_req = 1'b1;
      wr_req = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         exp_w = (mcnt == 8);
         chk("cont_rd_gnt", 32'(rd_gnt), 32'(!exp_w));
         chk("cont_wr_gnt", 32'(wr_gnt), 32'(exp_w));
         mcnt = exp_w ? 0 : mcnt + 1;
         @(posedge clk);
         #1;
         if (exp_w) begin
            chk("cont_mem_we_w", 32'(mem_we), 32'(1));
            chk("cont_mem_wdata_w", 32'(mem_wdata), 32'(wr_data));
            chk("cont_mem_addr_w", 32'(mem_addr), 32'(wr_addr));
            wr_addr = wr_addr + 20'd1;
            wr_data = wr_data + 17'h00111;
         end else begin
            chk("cont_mem_we_r", 32'(mem_we), 32'(0));
            chk("cont_mem_addr_r", 32'(mem_addr), 32'(rd_addr));
            chk("cont_mem_wdata_hold", 32'(mem_wdata), 32'(exp_wdata));
            rd_addr = rd_addr + 20'd1;
            rd_tag  = rd_tag + 4'd1;
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit any_valid;
      rst     = 1'b1;
      rd_req  = 1'b1;
      wr_req  = 1'b1;
      rd_addr = '0;
      rd_tag  = '0;
      wr_addr = '0;
      wr_data = '0;

      // Reset values and grant masking.
      repeat (2) @(negedge clk);
      chk("rst_rd_gnt", 32'(rd_gnt), 32'(0));
      chk("rst_wr_gnt", 32'(wr_gnt), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_rd_valid", 32'(rd_valid), 32'(0));
      chk("rst_rd_data", 32'(rd_data), 32'(0));
      chk("rst_rd_tag_out", 32'(rd_tag_out), 32'(0));
      chk("rst_outstanding", 32'(rd_outstanding), 32'(0));
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      rst    = 1'b0;

      // Single read.
      @(posedge clk);
      #1;
      rd_req  = 1'b1;
      rd_addr = 20'h00010;
      rd_tag  = 4'd3;
      @(negedge clk);
      chk("single_rd_gnt", 32'(rd_gnt), 32'(1));
      chk("single_wr_gnt", 32'(wr_gnt), 32'(0));
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      chk("single_mem_we", 32'(mem_we), 32'(0));
      chk("single_mem_addr", 32'(mem_addr), 32'h00010);
      chk("single_outstanding", 32'(rd_outstanding), 32'(1));
      any_valid = 1'b0;
      for (int i = 0; i < 10 && !any_valid; i++) begin
         @(negedge clk);
         any_valid = rd_valid;
      end
      chk("single_valid_seen", 32'(any_valid), 32'(1));
      chk("single_rd_data", 32'(rd_data), 32'h1ABCD);
      chk("single_rd_tag", 32'(rd_tag_out), 32'(3));
      drain();

      // Streaming reads.
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++) begin
         rd_req  = 1'b1;
         rd_addr = 20'(i);
         rd_tag  = 4'(i);
         @(negedge clk);
         chk("stream_rd_gnt", 32'(rd_gnt), 32'(1));
         if (i == 5) chk("stream_outstanding", 32'(rd_outstanding), 32'(5));
         @(posedge clk);
         #1;
      end
      rd_req = 1'b0;
      drain();

      // Contention: 8 reads, then a write, repeating.
      rd_addr = 20'h00100;
      rd_tag  = 4'd0;
      wr_addr = 20'h00200;
      wr_data = 17'h00100;
      run_contention(27);
      drain();

      // Write then read the same address.
      @(posedge clk);
      #1;
      wr_req  = 1'b1;
      wr_addr = 20'h00055;
      wr_data = 17'h0F0F0;
      @(negedge clk);
      chk("wrrd_wr_gnt", 32'(wr_gnt), 32'(1));
      @(posedge clk);
      #1;
      wr_req = 1'b0;
      chk("wrrd_mem_we", 32'(mem_we), 32'(1));
      chk("wrrd_mem_addr", 32'(mem_addr), 32'h00055);
      chk("wrrd_mem_wdata", 32'(mem_wdata), 32'h0F0F0);
      rd_req  = 1'b1;
      rd_addr = 20'h00055;
      rd_tag  = 4'd9;
      @(negedge clk);
      chk("wrrd_rd_gnt", 32'(rd_gnt), 32'(1));
      @(posedge clk);
      #1;
      rd_req    = 1'b0;
      any_valid = 1'b0;
      for (int i = 0; i < 10 && !any_valid; i++) begin
         @(negedge clk);
         any_valid = rd_valid;
      end
      chk("wrrd_valid_seen", 32'(any_valid), 32'(1));
      chk("wrrd_rd_data", 32'(rd_data), 32'h0F0F0);
      drain();

      // Reset with three reads in flight.
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         rd_req  = 1'b1;
         rd_addr = 20'h00300 + 20'(i);
         rd_tag  = 4'hA + 4'(i);
         @(negedge clk);
         chk("rstmid_rd_gnt", 32'(rd_gnt), 32'(1));
         @(posedge clk);
         #1;
      end
      rd_req = 1'b0;
      @(posedge clk);
      #1;
      rst    = 1'b1;
      rd_req = 1'b1;
      wr_req = 1'b1;
      #1;
      chk("rstmid_rd_gnt_masked", 32'(rd_gnt), 32'(0));
      chk("rstmid_wr_gnt_masked", 32'(wr_gnt), 32'(0));
      chk("rstmid_mem_addr", 32'(mem_addr), 32'(0));
      chk("rstmid_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rstmid_rd_valid", 32'(rd_valid), 32'(0));
      chk("rstmid_rd_data", 32'(rd_data), 32'(0));
      chk("rstmid_outstanding", 32'(rd_outstanding), 32'(0));
      @(posedge clk);
      #1;
      rst    = 1'b0;
      rd_req = 1'b0;
      wr_req = 1'b0;
      any_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         any_valid = any_valid | rd_valid;
      end
      chk("rstmid_no_valid_after", 32'(any_valid), 32'(0));
      @(posedge clk);
      #1;
      rd_req  = 1'b1;
      rd_addr = 20'h00010;
      rd_tag  = 4'd5;
      @(negedge clk);
      chk("post_rst_rd_gnt", 32'(rd_gnt), 32'(1));
      @(posedge clk);
      #1;
      rd_req = 1'b0;
      drain();

      // Write only, then contention to confirm the starve counter stayed clear.
      @(posedge clk);
      #1;
      wr_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_addr = 20'h003F0 + 20'(i);
         wr_data = 17'h01000 + 17'(i);
         @(negedge clk);
         chk("wronly_wr_gnt", 32'(wr_gnt), 32'(1));
         chk("wronly_rd_gnt", 32'(rd_gnt), 32'(0));
         @(posedge clk);
         #1;
         chk("wronly_mem_we", 32'(mem_we), 32'(1));
         chk("wronly_mem_wdata", 32'(mem_wdata), 32'(wr_data));
      end
      wr_req  = 1'b0;
      rd_addr = 20'h003F0;
      wr_addr = 20'h00380;
      wr_data = 17'h12345;
      run_contention(10);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single pipelined SRAM interface between two requesters: the capture path (write port) and the display scanout path (read port).
- Issues at most one operation per clock to the interface and tracks the fixed read latency so returned data can be tagged and validated.
- Read port has priority. A starvation counter guarantees the write port forward progress.
- Sits between the frame capture and scanout logic and the SRAM interface block.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 17, SRAM word width
- TAG_W, 4, opaque read tag width, returned with read data
- READ_LATENCY, 4, cycles from the interface latching a read to its data_out being stable
- WR_STARVE_MAX, 8, max consecutive cycles a pending write may be refused before it wins

Ports:
- clk  in  1  system clock (same clock as the SRAM interface)
- rst  in  1  asynchronous, active-high reset
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_tag  in  TAG_W  tag returned with data
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data/rd_tag_out valid (one-cycle pulse)
- rd_data  out  DATA_W  returned read data
- rd_tag_out  out  TAG_W  tag of returned data
- wr_req  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- mem_we  out  1  to interface write_enable (registered)
- mem_addr  out  ADDR_W  to interface addr (registered)
- mem_wdata  out  DATA_W  to interface data_in (registered)
- mem_rdata  in  DATA_W  from interface data_out
- rd_outstanding  out  3  reads in flight, for debug

Behaviour:
- Reset (async, rst=1): all of the following are 0:
  - mem_we, mem_addr, mem_wdata
  - rd_valid, rd_data, rd_tag_out
  - starve_cnt and the pipeline valid bits
  - rd_outstanding
- During reset, rd_gnt and wr_gnt are forced to 0.
- Grant is a combinational function of the request inputs and starve_cnt. A request is accepted at the posedge where req and gnt are both 1. The requester must hold addr/data/tag stable while req=1 and gnt=0.
- Arbitration each cycle:
  - Only rd_req: read granted.
  - Only wr_req: write granted.
  - Both, and starve_cnt < WR_STARVE_MAX: read granted.
  - Both, and starve_cnt == WR_STARVE_MAX: write granted.
  - Neither: idle.
- starve_cnt:
  - Increments (saturating at WR_STARVE_MAX) when wr_req=1 and wr_gnt=0.
  - Clears to 0 when the write is granted or when wr_req=0.
- Issue register, updated at the posedge after the grant:
  - Write granted: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - Read granted: mem_we=0, mem_addr=rd_addr, mem_wdata holds its previous value.
  - Idle: mem_we=0, mem_addr and mem_wdata hold. The resulting dummy read is untracked.
- Read return pipeline:
  - A shift register of depth READ_LATENCY+1 carries {valid, tag}.
  - A read granted at posedge N gives rd_valid=1 in the cycle after posedge N+READ_LATENCY+1 (6 cycles after grant with defaults).
  - rd_data is mem_rdata registered at that edge; rd_tag_out is the carried tag.
  - Back-to-back reads return back-to-back, in order.
- A write never produces rd_valid. Reads and writes interleave freely; the interface pipeline preserves order, so a read issued after a write to the same address returns the new data.
- rd_outstanding equals the number of valid bits in the pipeline (0..5). It is informational only and never stalls grants.
- rst asserted mid-operation: the pipeline is discarded, no rd_valid for in-flight reads, and outputs go to their reset values immediately.
- Requests held through reset are arbitrated normally from the first edge after deassertion.

Decomposition:
- Package sram_pkg holds SRAM_ADDR_W=20, SRAM_DATA_W=17, SRAM_READ_LATENCY=4, and the {valid, tag} struct typedef for pipeline entries.
- Sub-module sram_read_tracker: the parameterised {valid, tag} delay line plus the outstanding counter.
- The arbiter holds the grant logic, starve counter and issue register.

Test Plan:
- Single read: rd_req with addr 0x00010, tag 3; mem_rdata model returns 0x1ABCD → rd_gnt=1 the same cycle, mem_we=0 and mem_addr=0x00010 next cycle, rd_valid=1 with rd_data=0x1ABCD and tag 3 exactly 6 cycles after grant.
- Streaming reads: 16 consecutive reads, addr 0..15, tags 0..15 mod 16 → 16 consecutive rd_valid cycles, in order, with no gaps.
- Contention: rd_req and wr_req both held high continuously → first 8 cycles are read grants, cycle 9 is a write grant, then the pattern repeats (8 reads, 1 write).
- Write/read same address: write 0x00055 with data 0x0F0F0, then read 0x00055 → rd_data=0x0F0F0 and no rd_valid for the write.
- Reset mid-flight: grant 3 reads, assert rst 2 cycles later for 1 cycle → all outputs 0 at once, no rd_valid afterwards, and the next read after reset completes with 6-cycle latency.
- Write only: wr_req continuous, rd_req=0 → wr_gnt every cycle, starve_cnt stays 0, mem_we=1 each following cycle.
